// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit display scan controller.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Loadable down-counter with a done flag; times both the lit and blanking periods.
module scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Refresh controller for a 4-digit 7-segment display with blanking gaps and
// frame-synchronous value commit. Optional macro: LEADING_ZERO_BLANK_EN.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [15:0]      value_in,
    input  logic             value_load,
    output logic             load_ack,
    output logic [15:0]      disp_value,
    output logic [DIG_W-1:0] dig_sel,
    output logic [3:0]       an_n,
    output logic             frame_tick
);

    localparam int CNT_W = $clog2(max2(REFRESH_DIV, BLANK_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DIG_W-1:0] LAST_DIG   = DIG_W'(NUM_DIGITS - 1);

    scan_state_t      r_state, w_state_next;
    logic [DIG_W-1:0] r_dig_sel, w_dig_next;
    logic [15:0]      r_disp_value, r_staging;
    logic             r_pending, r_load_ack, r_frame_tick;

    logic             w_tmr_clr, w_tmr_load, w_tmr_done;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_frame_end, w_commit, w_lit;
    logic [3:0]       w_an_n;

    scan_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_tmr_clr),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_dig_next   = r_dig_sel;
        w_tmr_clr    = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_frame_end  = 1'b0;
        if (!enable) begin
            w_state_next = IDLE;
            w_dig_next   = '0;
            w_tmr_clr    = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_dig_next   = '0;
                    w_tmr_load   = 1'b1;
                    w_state_next = (BLANK_CYCLES == 0) ? SHOW : BLANK;
                    w_tmr_val    = (BLANK_CYCLES == 0) ? SHOW_LOAD : BLANK_LOAD;
                end
                BLANK: begin
                    if (w_tmr_done) begin
                        w_state_next = SHOW;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = SHOW_LOAD;
                    end
                end
                SHOW: begin
                    if (w_tmr_done) begin
                        w_dig_next   = r_dig_sel + 1'b1;
                        w_frame_end  = (r_dig_sel == LAST_DIG);
                        w_tmr_load   = 1'b1;
                        w_state_next = (BLANK_CYCLES == 0) ? SHOW : BLANK;
                        w_tmr_val    = (BLANK_CYCLES == 0) ? SHOW_LOAD : BLANK_LOAD;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_dig_next   = '0;
                    w_tmr_clr    = 1'b1;
                end
            endcase
        end
    end

    // A commit only happens when something is pending; a coincident load wins.
    assign w_commit = r_pending && ((r_state == IDLE) || w_frame_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_dig_sel    <= '0;
            r_disp_value <= '0;
            r_staging    <= '0;
            r_pending    <= 1'b0;
            r_load_ack   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_dig_sel    <= w_dig_next;
            r_frame_tick <= w_frame_end;
            r_load_ack   <= w_commit;
            if (w_commit) begin
                r_disp_value <= value_load ? value_in : r_staging;
                r_pending    <= 1'b0;
            end else if (value_load) begin
                r_staging <= value_in;
                r_pending <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_lit = 1'b1;
        unique case (r_dig_sel)
            2'd1:    w_lit = |r_disp_value[15:4];
            2'd2:    w_lit = |r_disp_value[15:8];
            2'd3:    w_lit = |r_disp_value[15:12];
            default: w_lit = 1'b1;
        endcase
    end
`else
    assign w_lit = 1'b1;
`endif

    always_comb begin
        w_an_n = 4'b1111;
        if (r_state == SHOW && w_lit) begin
            w_an_n = ~(4'b0001 << r_dig_sel);
        end
    end

    assign an_n       = w_an_n;
    assign dig_sel    = r_dig_sel;
    assign disp_value = r_disp_value;
    assign load_ack   = r_load_ack;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (REFRESH_DIV=4, BLANK_CYCLES=2):
// table-driven start-up, directed load/commit/reset sequences, random run.
module tb_display_scan_ctrl;

    localparam int R      = 4;
    localparam int B      = 2;
    localparam int PERIOD = R + B;
    localparam int FRAME  = 4 * PERIOD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] value_in;
    logic        value_load;
    logic        load_ack;
    logic [15:0] disp_value;
    logic [1:0]  dig_sel;
    logic [3:0]  an_n;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    display_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .value_in   (value_in),
        .value_load (value_load),
        .load_ack   (load_ack),
        .disp_value (disp_value),
        .dig_sel    (dig_sel),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: scan position within the frame plus load/commit bookkeeping.
    bit          m_active;
    int          m_pos;
    logic [15:0] m_disp, m_stage;
    bit          m_pend, m_ack, m_tick;

    task automatic model_edge(input bit rst, input bit en, input bit ld, input logic [15:0] v);
        bit fe;
        bit cp;
        if (rst) begin
            m_active = 0; m_pos = 0; m_disp = '0; m_stage = '0;
            m_pend = 0; m_ack = 0; m_tick = 0;
        end else begin
            fe = m_active && en && (m_pos == FRAME - 1);
            cp = !m_active || fe;
            m_tick = fe;
            m_ack  = 0;
            if (cp && m_pend) begin
                m_disp = ld ? v : m_stage;
                m_pend = 0;
                m_ack  = 1;
            end else if (ld) begin
                m_stage = v;
                m_pend  = 1;
            end
            if (!en) m_active = 0;
            else if (!m_active) begin m_active = 1; m_pos = 0; end
            else m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    function automatic logic [1:0] exp_dig();
        return m_active ? 2'(m_pos / PERIOD) : 2'd0;
    endfunction

    function automatic logic [3:0] exp_an();
        int d;
        bit lit;
        d   = m_pos / PERIOD;
        lit = m_active && ((m_pos % PERIOD) >= B);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (m_disp >> (4 * d)) == 16'h0) lit = 0;
`endif
        return lit ? ~(4'b0001 << d) : 4'b1111;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive, clock, then compare everything on the next negedge.
    task automatic step(input bit rst, input bit en, input bit ld, input logic [15:0] v);
        rst_n      = !rst;
        enable     = en;
        value_load = ld;
        value_in   = v;
        @(posedge clk);
        model_edge(rst, en, ld, v);
        @(negedge clk);
        check("an_n",       32'(an_n),       32'(exp_an()));
        check("dig_sel",    32'(dig_sel),    32'(exp_dig()));
        check("disp_value", 32'(disp_value), 32'(m_disp));
        check("load_ack",   32'(load_ack),   32'(m_ack));
        check("frame_tick", 32'(frame_tick), 32'(m_tick));
    endtask

    typedef struct {
        bit          en;
        bit          ld;
        logic [15:0] val;
        logic [3:0]  an;
        logic [1:0]  dig;
        bit          tick;
    } vec_t;

    vec_t vec [10];

    initial begin
        bit seen;
        int n_ack;
        bit en_r;

        vec[0] = '{1'b1, 1'b0, 16'h0, 4'b1111, 2'd0, 1'b0};
        vec[1] = '{1'b1, 1'b0, 16'h0, 4'b1111, 2'd0, 1'b0};
        vec[2] = '{1'b1, 1'b0, 16'h0, 4'b1110, 2'd0, 1'b0};
        vec[3] = '{1'b1, 1'b0, 16'h0, 4'b1110, 2'd0, 1'b0};
        vec[4] = '{1'b1, 1'b0, 16'h0, 4'b1110, 2'd0, 1'b0};
        vec[5] = '{1'b1, 1'b0, 16'h0, 4'b1110, 2'd0, 1'b0};
        vec[6] = '{1'b1, 1'b0, 16'h0, 4'b1111, 2'd1, 1'b0};
        vec[7] = '{1'b1, 1'b0, 16'h0, 4'b1111, 2'd1, 1'b0};
        vec[8] = '{1'b1, 1'b0, 16'h0, 4'b1101, 2'd1, 1'b0};
        vec[9] = '{1'b1, 1'b0, 16'h0, 4'b1101, 2'd1, 1'b0};

        rst_n = 1'b0; enable = 1'b0; value_load = 1'b0; value_in = '0;
        @(negedge clk);
        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
        check("reset_an_n", 32'(an_n), 32'hF);
        check("reset_disp", 32'(disp_value), 32'h0);
        step(0, 0, 0, 16'h0);

        // Scan start-up against fixed expectations.
        for (int i = 0; i < 10; i++) begin
            step(0, vec[i].en, vec[i].ld, vec[i].val);
            check("tbl_an_n",    32'(an_n),       32'(vec[i].an));
            check("tbl_dig_sel", 32'(dig_sel),    32'(vec[i].dig));
            check("tbl_tick",    32'(frame_tick), 32'(vec[i].tick));
        end

        // Mid-frame load commits only at frame end, together with frame_tick.
        step(0, 1, 0, 16'h0);
        step(0, 1, 1, 16'h1234);
        seen = 0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            step(0, 1, 0, 16'h0);
            if (load_ack) begin
                seen = 1;
                check("commit_value", 32'(disp_value), 32'h1234);
                check("commit_tick",  32'(frame_tick), 32'h1);
            end else begin
                check("hold_before_commit", 32'(disp_value), 32'h0);
            end
        end
        check("ack_seen", 32'(seen), 32'h1);

        // Two loads in one frame: last wins, one ack.
        step(0, 1, 1, 16'hAAAA);
        n_ack = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 16'h0);
            n_ack += int'(load_ack);
        end
        step(0, 1, 1, 16'h5555);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(0, 1, 0, 16'h0);
            n_ack += int'(load_ack);
        end
        check("single_ack", 32'(n_ack), 32'd1);
        check("last_wins",  32'(disp_value), 32'h5555);

        // Disabled: load commits from IDLE on the following edge.
        step(0, 0, 0, 16'h0);
        check("idle_dark", 32'(an_n), 32'hF);
        step(0, 0, 1, 16'hBEEF);
        step(0, 0, 0, 16'h0);
        check("idle_ack",  32'(load_ack),   32'h1);
        check("idle_disp", 32'(disp_value), 32'hBEEF);
        check("idle_an_n", 32'(an_n),       32'hF);

        // Synchronous reset in the middle of a SHOW period.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0);
        check("pre_reset_lit", 32'(an_n), 32'hE);
        step(1, 1, 0, 16'h0);
        check("mid_reset_an_n", 32'(an_n),       32'hF);
        check("mid_reset_dig",  32'(dig_sel),    32'h0);
        check("mid_reset_disp", 32'(disp_value), 32'h0);

        // Random traffic against the model, including enable drops.
        en_r = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) en_r = !en_r;
            step(0, en_r, ($urandom_range(0, 9) == 0), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
